// File: rtl/ram_seq_pkg.sv
// Shared definitions for the RAM timing sequencer: FSM encodings, timer width
// and default bus widths.
package ram_seq_pkg;

   localparam int unsigned TIMER_W    = 4;
   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      ACCESS   = 3'd2,
      RECOVER  = 3'd3,
      VRECOVER = 3'd4,
      VACCESS  = 3'd5
   } state_e;

endpackage

// File: rtl/ram_seq_timer.sv
// Loadable down-counter that times the strobe phase; saturates at zero.
module ram_seq_timer
   import ram_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               en,
   input  logic [TIMER_W-1:0] load_val,
   output logic               zero
);

   logic [TIMER_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ram_seq_ctrl.sv
// Frames valid/ready requests into setup/strobe/recover cycles for an async RAM.
// Optional write read-back verification: define RAM_SEQ_CTRL_WRVERIFY_EN.
module ram_seq_ctrl
   import ram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned ACCESS_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              wr_done,
   output logic              busy,
   output logic              ram_cs,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
  ,output logic              verify_err
`endif
);

   // A zero access length is treated as a single strobe cycle.
   localparam int unsigned ACC_EFF = (ACCESS_CYC == 0) ? 1 : ACCESS_CYC;
   localparam logic [TIMER_W-1:0] TMR_RELOAD = TIMER_W'(ACC_EFF - 1);

   state_e            state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [DATA_W-1:0] din_d, din_q;
   logic [DATA_W-1:0] rdata_d, rdata_q;
   logic              wr_lat_d, wr_lat_q;
   logic              cs_d, cs_q;
   logic              wr_d, wr_q;
   logic              rsp_valid_d, rsp_valid_q;
   logic              wr_done_d, wr_done_q;
   logic              busy_d, busy_q;
   logic              ready_d, ready_q;
   logic              tmr_load, tmr_en, tmr_zero;
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
   logic              verr_d, verr_q;
`endif

   ram_seq_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (TMR_RELOAD),
      .zero     (tmr_zero)
   );

   // Next state and next registered outputs, decoded from the state being entered.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      din_d    = din_q;
      wr_lat_d = wr_lat_q;
      rdata_d  = rdata_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
      verr_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d  = SETUP;
               addr_d   = req_addr;
               din_d    = req_wdata;
               wr_lat_d = req_wr;
            end
         end
         SETUP: begin
            tmr_load = 1'b1;
            state_d  = ACCESS;
         end
         ACCESS: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               if (!wr_lat_q) begin
                  rdata_d = ram_dout;
                  state_d = RECOVER;
               end else begin
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
                  state_d = VRECOVER;
`else
                  state_d = RECOVER;
`endif
               end
            end
         end
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
         VRECOVER: begin
            tmr_load = 1'b1;
            state_d  = VACCESS;
         end
         VACCESS: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               verr_d  = (ram_dout != din_q);
               state_d = RECOVER;
            end
         end
`endif
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cs_d        = (state_d == ACCESS) || (state_d == VACCESS);
      wr_d        = (state_d == ACCESS) && wr_lat_d;
      rsp_valid_d = (state_d == RECOVER) && !wr_lat_d;
      wr_done_d   = (state_d == RECOVER) && wr_lat_d;
      busy_d      = (state_d != IDLE);
      ready_d     = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         wr_lat_q    <= 1'b0;
         rdata_q     <= '0;
         cs_q        <= 1'b0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         wr_done_q   <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
         verr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         wr_lat_q    <= wr_lat_d;
         rdata_q     <= rdata_d;
         cs_q        <= cs_d;
         wr_q        <= wr_d;
         rsp_valid_q <= rsp_valid_d;
         wr_done_q   <= wr_done_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
         verr_q      <= verr_d;
`endif
      end
   end

   // Ready is withdrawn immediately while reset is asserted.
   assign req_ready = ready_q & ~rst;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign wr_done   = wr_done_q;
   assign busy      = busy_q;
   assign ram_cs    = cs_q;
   assign ram_wr    = wr_q;
   assign ram_addr  = addr_q;
   assign ram_din   = din_q;
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
   assign verify_err = verr_q;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed scoreboard bench for ram_seq_ctrl with a behavioural async RAM model.
module tb_ram_seq_ctrl;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 8;
   localparam int unsigned A  = 2;
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
   localparam int unsigned WR_LAT = 2 * A + 2;
`else
   localparam int unsigned WR_LAT = A + 1;
`endif
   localparam int unsigned RD_LAT = A + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          wr_done;
   logic          busy;
   logic          ram_cs;
   logic          ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          verify_err;

   ram_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYC(A)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done), .busy(busy),
      .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
     ,.verify_err(verify_err)
`endif
   );

`ifndef RAM_SEQ_CTRL_WRVERIFY_EN
   assign verify_err = 1'b0;
`endif

   always #5 clk = ~clk;

   // Behavioural RAM; 'stuck' forces data bit 0 low on reads.
   bit [DW-1:0] mem [0:(1<<AW)-1];
   bit          stuck = 1'b0;
   always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
   assign ram_dout = stuck ? (mem[ram_addr] & 8'hFE) : mem[ram_addr];

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit          is_wr;
      logic [7:0]  data;
      bit          verr;
      int unsigned acc;
   } exp_t;
   exp_t exp_q[$];
   bit [DW-1:0] ref_mem [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned last_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Response side: pop the scoreboard on every pulse, and watch bus invariants.
   logic          prev_cs = 1'b0, prev_rsp = 1'b0, prev_done = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_din = '0;
   always @(negedge clk) begin
      exp_t e;
      if (ram_wr && !ram_cs) chk("wr_without_cs", 32'(ram_wr), 32'(0));
      if (ram_cs && prev_cs) begin
         chk("addr_stable", 32'(ram_addr), 32'(prev_addr));
         chk("din_stable", 32'(ram_din), 32'(prev_din));
      end
      if (rsp_valid && prev_rsp) chk("rsp_pulse_width", 32'(1), 32'(0));
      if (wr_done && prev_done) chk("done_pulse_width", 32'(1), 32'(0));
      if (rsp_valid || wr_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'({rsp_valid, wr_done}), 32'(0));
         end else begin
            e = exp_q.pop_front();
            chk("rsp_kind", 32'({rsp_valid, wr_done}), e.is_wr ? 32'(1) : 32'(2));
            chk("latency", 32'(cyc - e.acc), e.is_wr ? 32'(WR_LAT) : 32'(RD_LAT));
            if (!e.is_wr) chk("rdata", 32'(rsp_rdata), 32'(e.data));
`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
            if (e.is_wr) chk("verify_err", 32'(verify_err), 32'(e.verr));
`endif
         end
      end
      prev_cs   = ram_cs;
      prev_addr = ram_addr;
      prev_din  = ram_din;
      prev_rsp  = rsp_valid;
      prev_done = wr_done;
   end

   // Present a request at a negedge and wait (bounded) for it to be taken; valid stays high.
   task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exp_t e;
      bit   taken = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = data;
      for (int i = 0; i < 60 && !taken; i++) begin
         if (req_ready) begin
            @(posedge clk);
            #1;
            taken      = 1'b1;
            e.is_wr    = wr;
            e.acc      = cyc;
            e.verr     = stuck && data[0];
            if (wr) ref_mem[addr] = data;
            e.data     = ref_mem[addr];
            exp_q.push_back(e);
            last_acc   = cyc;
         end else begin
            @(negedge clk);
         end
      end
      if (!taken) chk("accept_timeout", 32'(0), 32'(1));
   endtask

   task automatic idle_in();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
      repeat (2) @(negedge clk);
   endtask

   int unsigned prev_acc;
   logic [7:0]  pat_d [4];
   logic [9:0]  pat_a [4];

   initial begin
      pat_d[0] = 8'hAC; pat_d[1] = 8'h9B; pat_d[2] = 8'h8F; pat_d[3] = 8'h7F;
      pat_a[0] = 10'd64; pat_a[1] = 10'd128; pat_a[2] = 10'd256; pat_a[3] = 10'd512;

      // Reset then idle
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'(1));
      chk("rst_cs", 32'(ram_cs), 32'(0));
      chk("rst_wr", 32'(ram_wr), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_wr_done", 32'(wr_done), 32'(0));
      chk("rst_rdata", 32'(rsp_rdata), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_addr", 32'(ram_addr), 32'(0));

      // Single write: strobe window and model contents
      do_req(1'b1, 10'd32, 8'hFF);
      req_valid = 1'b0;
      for (int i = 0; i <= int'(A) + 1; i++) begin
         @(negedge clk);
         chk("w32_cs", 32'(ram_cs), 32'(i >= 1 && i <= int'(A)));
         chk("w32_wr", 32'(ram_wr), 32'(i >= 1 && i <= int'(A)));
         chk("w32_busy", 32'(busy), 32'(1));
      end
      drain();
      chk("w32_mem", 32'(mem[32]), 32'(8'hFF));

      // Back-to-back writes then reads with valid held high
      for (int k = 0; k < 4; k++) begin
         prev_acc = last_acc;
         do_req(1'b1, pat_a[k], pat_d[k]);
         if (k > 0) chk("wr_period", 32'(last_acc - prev_acc), 32'(WR_LAT + 2));
      end
      for (int k = 0; k < 4; k++) begin
         prev_acc = last_acc;
         do_req(1'b0, pat_a[k], 8'h00);
         if (k > 0) chk("rd_period", 32'(last_acc - prev_acc), 32'(A + 3));
      end
      idle_in();
      drain();
      chk("rdata_hold", 32'(rsp_rdata), 32'(8'h7F));

      // Request during ACCESS must be ignored
      do_req(1'b0, 10'd64, 8'h00);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ign_in_access", 32'(ram_cs), 32'(1));
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'd700; req_wdata = 8'h55;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ign_addr", 32'(ram_addr), 32'(64));
      drain();
      chk("ign_mem700", 32'(mem[700]), 32'(0));

      // Top address
      do_req(1'b1, 10'd1023, 8'h5A);
      do_req(1'b0, 10'd1023, 8'h00);
      idle_in();
      drain();

      // Reset during second ACCESS cycle of a read
      do_req(1'b0, 10'd128, 8'h00);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_access", 32'(ram_cs), 32'(1));
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_cs", 32'(ram_cs), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_ready", 32'(req_ready), 32'(1));
      chk("abort_rdata", 32'(rsp_rdata), 32'(0));
      repeat (6) @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'(0));

`ifdef RAM_SEQ_CTRL_WRVERIFY_EN
      // Read-back verify against a RAM with bit 0 stuck low
      stuck = 1'b1;
      do_req(1'b1, 10'd1023, 8'h01);
      do_req(1'b1, 10'd1023, 8'h02);
      idle_in();
      drain();
      stuck = 1'b0;
`endif

      chk("final_queue", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Timing sequencer between a valid/ready request source and an asynchronous 8-bit RAM. The RAM has ports addr, wr, cs, data_in and data_out, and has no clock.
- Converts single-cycle requests into properly framed RAM cycles: address setup, then a cs/wr strobe held for a parameterised number of cycles, then recovery.
- Returns read data on a one-cycle response pulse.
- Sits directly upstream of the RAM and drives every one of its inputs.

Parameters:
- ADDR_W, 10, RAM address width (1024 locations).
- DATA_W, 8, data width.
- ACCESS_CYC, 2, number of cycles cs (and wr, for writes) is held active. Legal range 1..15; a value of 0 behaves as 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  DATA_W  read data.
- wr_done  out  1  one-cycle pulse when a write completes.
- busy  out  1  high whenever the controller is not in IDLE.
- ram_cs  out  1  RAM chip select.
- ram_wr  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data.

Behaviour:
- Reset (synchronous): on any edge with rst=1, state=IDLE.
  - Zeroed outputs: ram_cs, ram_wr, rsp_valid, wr_done, busy, ram_addr, ram_din, rsp_rdata.
  - req_ready=1 from the first cycle after reset.
- A reset mid-access aborts the access at that edge. A write may be left partial; no rsp_valid or wr_done is emitted.
- Handshake: a request is accepted on an edge where req_valid & req_ready. All request fields are latched at that edge.
- req_ready = (state==IDLE) & ~rst. Requests seen while not in IDLE are ignored, with no loss of the held request.
- All outputs are registered.
- IDLE: cs=0, wr=0. On accept, go to SETUP.
- SETUP (1 cycle): ram_addr and ram_din show the latched values; cs=0, wr=0. Load timer with ACCESS_CYC-1. Go to ACCESS.
- ACCESS (ACCESS_CYC cycles): cs=1; wr equals the latched req_wr; addr and din held stable.
  - For a read, rsp_rdata captures ram_dout at the edge that ends the last ACCESS cycle.
  - When the timer reaches 0, go to RECOVER.
- RECOVER (1 cycle): cs=0, wr=0; addr and din still held.
  - rsp_valid=1 for a read, or wr_done=1 for a write. Exactly one pulse, one cycle.
  - Go to IDLE.
- Latency: request accepted at edge T; response pulse in cycle T+ACCESS_CYC+2.
- Throughput: back-to-back requests accepted every ACCESS_CYC+3 cycles.
- ram_wr is never 1 while ram_cs is 0.
- ram_addr and ram_din never change while ram_cs=1.
- rsp_rdata holds its value until the next read completes.
- Address range: all ADDR_W values are legal; address 2^ADDR_W-1 needs no special handling.

Optional Feature:
- Macro: RAM_SEQ_CTRL_WRVERIFY_EN.
- When defined:
  - After a write's ACCESS phase, the FSM passes through VRECOVER (cs=0, 1 cycle), then VACCESS (read of the same address, ACCESS_CYC cycles), then RECOVER.
  - At RECOVER, wr_done pulses together with a new output verify_err (1 bit), which is 1 if the read-back differs from the written data.
  - Write latency becomes 2*ACCESS_CYC+3; read latency is unchanged.
- When undefined: the verify_err port and the verify states do not exist.

Decomposition:
- Shared package/include ram_seq_pkg:
  - state encodings IDLE, SETUP, ACCESS, RECOVER, VRECOVER, VACCESS (3-bit);
  - TIMER_W=4;
  - default ADDR_W and DATA_W constants.
- One sub-module, ram_seq_timer: loadable 4-bit down-counter with load, en and zero outputs. Instantiated once; the FSM stays in the parent.

Test Plan:
- Reset, then idle 5 cycles -> req_ready=1; cs, wr, rsp_valid and wr_done all 0; rsp_rdata=0x00.
- Write addr 32 data 0xFF, ACCESS_CYC=2 -> cs=1 and wr=1 for exactly cycles T+2..T+3; wr_done at T+4; RAM behavioural model mem[32]=0xFF.
- Write 0xAC@64, 0x9B@128, 0x8F@256, 0x7F@512 with req_valid held high, then read each address -> accepts every 5 cycles; rsp_rdata = 0xAC, 0x9B, 0x8F, 0x7F; each rsp_valid is a single cycle.
- req_valid pulsed in the ACCESS cycle with a different addr -> ignored; ram_addr stable; only the original access completes.
- rst asserted in the 2nd ACCESS cycle of a read -> next cycle cs=0, state IDLE; no rsp_valid; req_ready=1.
- With RAM_SEQ_CTRL_WRVERIFY_EN and a model forcing bit 0 stuck low: write 0x01@1023 -> wr_done and verify_err=1 at T+7; write 0x02 -> verify_err=0.
